// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit controller.
//   - RV32 funct3 width codes for loads and stores
//   - FSM state enum for lsu_ctrl (exported on its fsm_state port)
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  // Stores only know B/H/W; loads additionally know the unsigned variants.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load result extension.
// Turns the zero-extended low bytes returned by data memory into the
// architectural load value selected by funct3.
// Ports:
//   funct3 - load width/sign code (B, H, W, BU, HU)
//   rdata  - raw memory read data
//   data   - sign/zero-extended load result (0 for unknown codes)
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  always_comb begin
    data = '0;
    case (funct3)
      F3_B:    data = {{24{rdata[7]}}, rdata[7:0]};
      F3_H:    data = {{16{rdata[15]}}, rdata[15:0]};
      F3_W:    data = rdata;
      F3_BU:   data = {24'b0, rdata[7:0]};
      F3_HU:   data = {16'b0, rdata[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller between the core and data memory.
// Accepts one request at a time, checks it, performs a single memory
// access and returns an extended load result or an error flag.
//
// Configuration macro: LSU_ALIGN_CHECK_EN
//   defined   - misaligned half/word accesses are rejected with resp_err
//   undefined - misaligned accesses are allowed; the low address bits sent
//               to memory are cleared to the natural alignment
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/req_ready   - request handshake (req_ready only in IDLE)
//   req_we, req_funct3    - store flag and RV32 width code
//   req_addr, req_wdata   - byte address and low-aligned store data
//   resp_valid/resp_ready - response handshake
//   resp_data, resp_err   - extended load value (0 for stores/errors), error
//   mem_ren, mem_wen      - one-cycle memory read/write strobes
//   mem_funct3, mem_addr  - access width code and byte address
//   mem_wdata, mem_rdata  - store data out, read data in (cycle after mem_ren)
//   fsm_state             - current controller state, for observation
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A request is captured on that edge, so request inputs may change
// afterwards. A response holds resp_data/resp_err stable until its transfer.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_err,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output lsu_state_e            fsm_state
);

  lsu_state_e            state, state_next;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           data_q;
  logic                  err_q;
  logic                  accept;
  logic                  req_illegal;
  logic                  align_bad;
  logic [31:0]           ext_data;
  logic [ADDR_WIDTH-1:0] addr_aligned;

  assign accept = req_valid && (state == IDLE);

  // Request legality, evaluated on the live request inputs in IDLE.
  always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
    align_bad = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    align_bad = 1'b0;
`endif
    req_illegal = !funct3_legal(req_we, req_funct3) ||
                  (|(req_addr >> ADDR_WIDTH)) ||
                  align_bad;
  end

  // Address presented to memory. With alignment checking on, misaligned
  // requests never reach ACCESS, so the captured address is used as is.
  always_comb begin
    addr_aligned = addr_q;
`ifndef LSU_ALIGN_CHECK_EN
    if (f3_q[1:0] == 2'b01) addr_aligned[0] = 1'b0;
    else if (f3_q[1:0] == 2'b10) addr_aligned[1:0] = 2'b00;
`endif
  end

  lsu_load_ext u_load_ext (
    .funct3 (f3_q),
    .rdata  (mem_rdata),
    .data   (ext_data)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_illegal ? RESP : ACCESS;
      ACCESS:  state_next = we_q ? RESP : WAIT;
      WAIT:    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs. Memory-side outputs are zero outside ACCESS, so a reset
  // mid-access removes the strobe immediately.
  always_comb begin
    req_ready  = (state == IDLE);
    mem_ren    = (state == ACCESS) && !we_q;
    mem_wen    = (state == ACCESS) && we_q;
    mem_funct3 = (state == ACCESS) ? {1'b0, f3_q[1:0]} : 3'b000;
    mem_addr   = (state == ACCESS) ? addr_aligned : '0;
    mem_wdata  = ((state == ACCESS) && we_q) ? wdata_q : 32'b0;
    resp_valid = (state == RESP);
    resp_data  = (state == RESP) ? data_q : 32'b0;
    resp_err   = (state == RESP) && err_q;
    fsm_state  = state;
  end

  // Captured request and response payload. data_q is cleared at acceptance
  // so stores and rejected requests answer with zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'b0;
      data_q  <= 32'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr[ADDR_WIDTH-1:0];
      wdata_q <= req_wdata;
      data_q  <= 32'b0;
      err_q   <= req_illegal;
    end else if (state == WAIT) begin
      data_q  <= ext_data;
    end
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, data_memo byte-address width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_ready  output  1  lsu_ctrl can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, low-aligned.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  core accepts response.
REQ-012 resp_data  output  32  extended load result; 0 for stores and errors.
REQ-013 resp_err  output  1  request rejected (misaligned, illegal funct3, out of range).
REQ-014 mem_ren, mem_wen  output  1 each  data_memo read/write enables.
REQ-015 mem_funct3  output  3  width code to data_memo.
REQ-016 mem_addr  output  ADDR_WIDTH  byte address to data_memo.
REQ-017 mem_wdata  output  32  store data to data_memo.
REQ-018 mem_rdata  input  32  data_memo read data, zero-extended low bytes, valid the cycle after mem_ren.

Function
REQ-019 FSM states IDLE, ACCESS, WAIT, RESP; req_ready=1 only in IDLE.
REQ-020 IDLE: on req_valid&&req_ready, register we/funct3/addr/wdata; legal -> ACCESS, illegal -> RESP with err set.
REQ-021 Illegal: load funct3 in {011,110,111}; store funct3 not in {000,001,010}; req_addr[31:ADDR_WIDTH] nonzero; misalignment per REQ-033.
REQ-022 ACCESS: exactly one cycle of mem_ren (load) or mem_wen (store); mem_addr=req_addr[ADDR_WIDTH-1:0]; mem_funct3={1'b0,funct3[1:0]}.
REQ-023 ACCESS -> WAIT for loads, -> RESP for stores.
REQ-024 WAIT: register resp_data from mem_rdata: funct3 000 sign-extend bit 7, 001 sign-extend bit 15, 010 pass, 100 zero-extend byte, 101 zero-extend half; -> RESP.
REQ-025 RESP: resp_valid=1, resp_data/resp_err stable until resp_valid&&resp_ready, then -> IDLE.
REQ-026 Latency, acceptance edge to resp_valid: load 3 cycles, store 2, error 1; back-to-back throughput one request per 4 / 3 / 2 cycles with resp_ready held high.
REQ-027 mem_ren/mem_wen never asserted outside ACCESS, never together, never for an illegal request.
REQ-028 req_valid ignored outside IDLE; request inputs need not be held after acceptance.

Reset
REQ-029 rst_n low asynchronously forces IDLE; req_ready=1 after release, all other outputs 0.
REQ-030 Reset in ACCESS drops mem_wen/mem_ren immediately; in-flight request discarded, no response.
REQ-031 First acceptance is possible on the first rising edge with rst_n high.

Configuration
REQ-032 Macro LSU_ALIGN_CHECK_EN selects alignment handling.
REQ-033 Defined: half with addr[0]!=0 or word with addr[1:0]!=0 is illegal -> resp_err=1, no memory access.
REQ-034 Undefined: no alignment error; mem_addr low bits forced to zero (half: bit 0, word: bits 1:0); remaining checks unchanged.

Structure
REQ-035 Package lsu_pkg holds funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state enum.
REQ-036 Sub-module lsu_load_ext: combinational funct3-driven sign/zero extension used in WAIT.
REQ-037 lsu_ctrl instantiates no memory; it connects to data_memo at the top level.

Verification
REQ-038 SB addr 0x10 wdata 0x000000AA -> one mem_wen cycle, mem_funct3=000; then LB 0x10 -> resp_data 0xFFFFFFAA, LBU -> 0x000000AA.
REQ-039 SH 0x20 0x0000BEEF then LH 0x20 -> 0xFFFFBEEF 3 cycles after acceptance; LHU -> 0x0000BEEF.
REQ-040 SW 0x30 0xDEADBEEF then LW 0x30 -> 0xDEADBEEF; resp_ready low 5 cycles -> resp_valid/resp_data held, req_ready=0.
REQ-041 LW 0x32: with LSU_ALIGN_CHECK_EN resp_err=1 after 1 cycle, no mem_ren; without, mem_addr=0x30, resp_data 0xDEADBEEF.
REQ-042 funct3 011 load, and req_addr 0x00000100 with ADDR_WIDTH=8 -> resp_err=1, resp_data=0, no mem enables.
REQ-043 rst_n low during store ACCESS -> mem_wen drops asynchronously, no resp_valid, req_ready=1 after release.
